// File: rtl/raycast_column_sequencer.sv
// raycast_column_sequencer
//   Frame-level controller for the ray-caster. On a frame request it latches
//   the player pose, then casts every screen column 0..WIDTH-1 in order over
//   a start/done handshake. Each result becomes one 20-bit frame-buffer entry
//   {bottom, top, color}.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     frame_req                 one-cycle frame render request
//     angle_in/pos_*_in/shot_in pose inputs, sampled only in LATCH
//     cast_*  (out)             start pulse, column, latched pose for the caster
//     cast_busy/done/height/color  caster status and result
//     fb_we/fb_addr/fb_data     frame-buffer write port, one write per column
//     frame_busy/frame_done     frame activity and end-of-frame pulse
//     frame_count/timeout_cnt   completed frames (wrapping), timed-out columns (saturating)
//     overrun                   sticky: request arrived while one was already pending
//
//   state   | meaning
//   S_IDLE  | waiting for frame_req
//   S_LATCH | snapshot pose, column 0
//   S_ISSUE | start pulse once the caster is not busy
//   S_WAIT  | waiting for done or the column timeout
//   S_WRITE | frame-buffer write of the current column
//   S_NEXT  | advance column or finish the frame

module raycast_column_sequencer #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_req,
    input  logic [79:0] angle_in,
    input  logic [15:0] pos_x_in,
    input  logic [15:0] pos_y_in,
    input  logic        shot_in,
    output logic        cast_start,
    output logic [8:0]  cast_x,
    output logic [79:0] cast_angle,
    output logic [15:0] cast_pos_x,
    output logic [15:0] cast_pos_y,
    output logic        cast_shot,
    input  logic        cast_busy,
    input  logic        cast_done,
    input  logic [7:0]  cast_height,
    input  logic [3:0]  cast_color,
    output logic        fb_we,
    output logic [8:0]  fb_addr,
    output logic [19:0] fb_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [12:0] frame_count,
    output logic [7:0]  timeout_cnt,
    output logic        overrun
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [8:0]       LAST_COL = 9'(WIDTH - 1);
    localparam logic [7:0]       HEIGHT_C = 8'(HEIGHT);
    // Timer reaches zero on the TIMEOUT-th WAIT cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_NEXT
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        col_q, col_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        height_q, height_d;
    logic [3:0]        color_q, color_d;
    logic [79:0]       angle_q, angle_d;
    logic [15:0]       pos_x_q, pos_x_d;
    logic [15:0]       pos_y_q, pos_y_d;
    logic              shot_q, shot_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [12:0]       frame_count_q, frame_count_d;
    logic [7:0]        timeout_cnt_q, timeout_cnt_d;

    logic [7:0]        h_clamp, span, top, bottom;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            tmr_q         <= '0;
            height_q      <= '0;
            color_q       <= '0;
            angle_q       <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            shot_q        <= 1'b0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            tmr_q         <= tmr_d;
            height_q      <= height_d;
            color_q       <= color_d;
            angle_q       <= angle_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            shot_q        <= shot_d;
            pending_q     <= pending_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Line geometry from the captured result: clamp, centre, extend.
    always_comb begin
        h_clamp = (height_q > HEIGHT_C) ? HEIGHT_C : height_q;
        span    = HEIGHT_C - h_clamp;
        top     = {1'b0, span[7:1]};
        bottom  = top + h_clamp;
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        tmr_d         = tmr_q;
        height_d      = height_q;
        color_d       = color_q;
        angle_d       = angle_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        shot_d        = shot_q;
        pending_d     = pending_q;
        overrun_d     = overrun_q;
        frame_count_d = frame_count_q;
        timeout_cnt_d = timeout_cnt_q;
        cast_start    = 1'b0;
        fb_we         = 1'b0;
        frame_done    = 1'b0;

        // One-deep request queue. LATCH consumes the pending request, but a
        // request landing in that same cycle re-arms it.
        if (state_q == S_LATCH) begin
            pending_d = frame_req;
        end else if (state_q != S_IDLE && frame_req) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_req) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                angle_d = angle_in;
                pos_x_d = pos_x_in;
                pos_y_d = pos_y_in;
                shot_d  = shot_in;
                col_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!cast_busy) begin
                    cast_start = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // done takes priority over an expiring timer
                if (cast_done) begin
                    height_d = cast_height;
                    color_d  = cast_color;
                    state_d  = S_WRITE;
                end else if (tmr_q == '0) begin
                    height_d = '0;
                    color_d  = '0;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                    state_d = S_WRITE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WRITE: begin
                fb_we   = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (col_q < LAST_COL) begin
                    col_d   = col_q + 9'd1;
                    state_d = S_ISSUE;
                end else begin
                    frame_done    = 1'b1;
                    frame_count_d = frame_count_q + 13'd1;
                    // A request arriving in this very cycle also starts the next frame.
                    state_d = (pending_q || frame_req) ? S_LATCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cast_x      = col_q;
    assign cast_angle  = angle_q;
    assign cast_pos_x  = pos_x_q;
    assign cast_pos_y  = pos_y_q;
    assign cast_shot   = shot_q;
    assign fb_addr     = fb_we ? col_q : 9'd0;
    assign fb_data     = fb_we ? {bottom, top, color_q} : 20'd0;
    assign frame_busy  = (state_q != S_IDLE);
    assign frame_count = frame_count_q;
    assign timeout_cnt = timeout_cnt_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_raycast_column_sequencer.sv
module tb_raycast_column_sequencer;

    localparam int WIDTH   = 320;
    localparam int HEIGHT  = 240;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        frame_req;
    logic [79:0] angle_in;
    logic [15:0] pos_x_in;
    logic [15:0] pos_y_in;
    logic        shot_in;
    logic        cast_start;
    logic [8:0]  cast_x;
    logic [79:0] cast_angle;
    logic [15:0] cast_pos_x;
    logic [15:0] cast_pos_y;
    logic        cast_shot;
    logic        cast_busy;
    logic        cast_done;
    logic [7:0]  cast_height;
    logic [3:0]  cast_color;
    logic        fb_we;
    logic [8:0]  fb_addr;
    logic [19:0] fb_data;
    logic        frame_busy;
    logic        frame_done;
    logic [12:0] frame_count;
    logic [7:0]  timeout_cnt;
    logic        overrun;

    raycast_column_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .frame_req(frame_req),
        .angle_in(angle_in), .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .shot_in(shot_in),
        .cast_start(cast_start), .cast_x(cast_x), .cast_angle(cast_angle),
        .cast_pos_x(cast_pos_x), .cast_pos_y(cast_pos_y), .cast_shot(cast_shot),
        .cast_busy(cast_busy), .cast_done(cast_done), .cast_height(cast_height),
        .cast_color(cast_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_count(frame_count),
        .timeout_cnt(timeout_cnt), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference column entry: clamp to screen height, centre the line.
    function automatic logic [19:0] ref_entry(input int h, input int c);
        int hc;
        int top;
        hc  = (h < HEIGHT) ? h : HEIGHT;
        top = (HEIGHT - hc) / 2;
        return {8'(top + hc), 8'(top), 4'(c)};
    endfunction

    logic [112:0] cast_pose, in_pose;
    assign cast_pose = {cast_angle, cast_pos_x, cast_pos_y, cast_shot};
    assign in_pose   = {angle_in, pos_x_in, pos_y_in, shot_in};

    // ---------------- caster model ----------------
    bit cm_rand_delay = 0;
    int cm_delay      = 5;
    bit cm_never      = 0;
    int cm_hmode      = 0;
    int cm_h          = 100;
    int cm_c          = 2;
    int cm_cnt        = 0;
    int cm_col        = 0;
    int hh, cc;
    logic [19:0] exp_q[$];

    initial begin
        cast_done   = 1'b0;
        cast_height = '0;
        cast_color  = '0;
        forever begin
            @(negedge clk);
            cast_done = 1'b0;
            if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    if (cm_hmode == 0) begin
                        hh = cm_h; cc = cm_c;
                    end else if (cm_col == 0) begin
                        hh = 255; cc = 10;
                    end else if (cm_col == 1) begin
                        hh = 0; cc = 10;
                    end else begin
                        hh = int'($urandom_range(255, 0));
                        cc = int'($urandom_range(15, 0));
                    end
                    cast_done   = 1'b1;
                    cast_height = 8'(hh);
                    cast_color  = 4'(cc);
                    exp_q.push_back(ref_entry(hh, cc));
                end
            end
            if (!rst && cast_start && !cm_never) begin
                cm_col = int'(cast_x);
                cm_cnt = cm_rand_delay ? int'($urandom_range(8, 1)) : cm_delay;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    int cyc = 0;
    int st_col = 0;
    int wr_col = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_we_cyc = 0;
    int we_gap = 0;
    logic [112:0] frame_pose = '0;
    logic [19:0]  fb_mem [WIDTH];
    logic [19:0]  exp_d;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cast_start) begin
                check("cast_x", cast_x, st_col);
                if (st_col == 0) begin
                    check("pose_latch", cast_pose, in_pose);
                    frame_pose = in_pose;
                end else begin
                    check("pose_stable", cast_pose, frame_pose);
                end
                st_col = (st_col + 1) % WIDTH;
            end
            if (fb_we) begin
                check("fb_addr", fb_addr, wr_col);
                if (cm_never) begin
                    check("fb_data_timeout", fb_data, ref_entry(0, 0));
                end else if (exp_q.size() == 0) begin
                    check("exp_q_size", exp_q.size(), 1);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("fb_data", fb_data, exp_d);
                end
                fb_mem[wr_col] = fb_data;
                we_gap      = cyc - last_we_cyc;
                last_we_cyc = cyc;
                wr_count++;
                wr_col = (wr_col + 1) % WIDTH;
            end
            if (frame_done) begin
                done_count++;
                check("done_after_last_col", wr_col, 0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic new_pose();
        angle_in = {$urandom(), $urandom(), 16'($urandom())};
        pos_x_in = 16'($urandom());
        pos_y_in = 16'($urandom());
        shot_in  = 1'($urandom());
    endtask

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic pulse_req();
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_busy && n < max);
        check(tag, frame_busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_start_col(input string tag, input int col, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cast_start && cast_x == 9'(col)) && n < max);
        check(tag, n < max, 1);
    endtask

    task automatic wait_frame_done(input string tag, input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < max);
        check(tag, frame_done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cast_start"}, cast_start, 0);
        check({tag, "_cast_x"}, cast_x, 0);
        check({tag, "_cast_pose"}, cast_pose, 0);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_frame_busy"}, frame_busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_timeout_cnt"}, timeout_cnt, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    int base_wr, base_done, starts;

    initial begin
        rst = 1'b1; frame_req = 1'b0; cast_busy = 1'b0;
        angle_in = '0; pos_x_in = '0; pos_y_in = '0; shot_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        new_pose();
        @(posedge clk); #1;

        // 1: fixed caster, height 100, colour 2
        cm_delay = 5; cm_hmode = 0; cm_h = 100; cm_c = 2;
        base_wr = wr_count; base_done = done_count;
        pulse_req();
        @(negedge clk);
        check("latch_no_start", cast_start, 0);
        check("latch_busy", frame_busy, 1);
        @(negedge clk);
        check("start_latency", cast_start, 1);
        repeat (30) @(posedge clk);
        #1 new_pose();
        wait_idle("f1_idle", 5000);
        check("f1_writes", wr_count - base_wr, WIDTH);
        check("f1_done", done_count - base_done, 1);
        check("f1_count", frame_count, 1);
        check("f1_first", fb_mem[0], {8'd170, 8'd70, 4'd2});
        check("f1_last", fb_mem[WIDTH-1], {8'd170, 8'd70, 4'd2});
        check("f1_col_cost", we_gap, 8);

        // 2: random delays and heights; clamp and zero-height boundaries
        cm_rand_delay = 1; cm_hmode = 1;
        base_wr = wr_count; base_done = done_count;
        pulse_req();
        wait_idle("f2_idle", 8000);
        check("f2_writes", wr_count - base_wr, WIDTH);
        check("f2_done", done_count - base_done, 1);
        check("f2_clamp", fb_mem[0], {8'd240, 8'd0, 4'hA});
        check("f2_zero", fb_mem[1], {8'd120, 8'd120, 4'hA});
        check("f2_count", frame_count, 2);

        // 3: two requests mid-frame -> overrun, exactly one back-to-back frame
        cm_rand_delay = 0; cm_delay = 5;
        base_wr = wr_count; base_done = done_count;
        pulse_req();
        wait_start_col("f3_col10", 10, 200);
        @(posedge clk); #1;
        pulse_req();
        new_pose();
        @(negedge clk);
        check("f3_no_overrun", overrun, 0);
        wait_start_col("f3_col20", 20, 200);
        @(posedge clk); #1;
        pulse_req();
        @(negedge clk);
        check("f3_overrun", overrun, 1);
        wait_frame_done("f3_first_done", 4000);
        @(negedge clk);
        check("f3_latch_direct", frame_busy, 1);
        @(negedge clk);
        check("f3_restart", cast_start, 1);
        wait_idle("f3_idle", 4000);
        check("f3_done", done_count - base_done, 2);
        check("f3_writes", wr_count - base_wr, 2 * WIDTH);
        check("f3_count", frame_count, 4);
        repeat (20) @(negedge clk);
        check("f3_no_third", frame_busy, 0);
        @(posedge clk); #1;

        // 4: done and timeout in the same cycle -> done wins
        cm_hmode = 0; cm_delay = TIMEOUT; cm_h = 100; cm_c = 3;
        pulse_req();
        wait_idle("f4_idle", 8000);
        check("f4_timeouts", timeout_cnt, 0);
        check("f4_data", fb_mem[WIDTH-1], {8'd170, 8'd70, 4'd3});
        check("f4_col_cost", we_gap, TIMEOUT + 3);
        check("f4_count", frame_count, 5);

        // 5: caster never answers -> every column times out
        cm_never = 1;
        base_wr = wr_count;
        pulse_req();
        wait_idle("f5_idle", 8000);
        cm_never = 0;
        check("f5_writes", wr_count - base_wr, WIDTH);
        check("f5_timeout_sat", timeout_cnt, 255);
        check("f5_data", fb_mem[100], {8'd120, 8'd120, 4'd0});
        check("f5_col_cost", we_gap, TIMEOUT + 3);
        check("f5_count", frame_count, 6);

        // 6: caster busy for 7 cycles in ISSUE
        cm_delay = 5; cm_h = 60; cm_c = 7;
        cast_busy = 1'b1;
        pulse_req();
        starts = 0;
        repeat (8) begin
            @(negedge clk);
            if (cast_start) starts++;
        end
        check("f6_held", starts, 0);
        check("f6_busy_frame", frame_busy, 1);
        @(posedge clk); #1;
        cast_busy = 1'b0;
        starts = 0;
        repeat (4) begin
            @(negedge clk);
            if (cast_start) starts++;
        end
        check("f6_one_start", starts, 1);
        wait_idle("f6_idle", 5000);
        check("f6_data", fb_mem[5], {8'd150, 8'd90, 4'd7});
        check("f6_count", frame_count, 7);

        // 7: reset in WAIT at column 50, then a clean restart
        cm_h = 100; cm_c = 2;
        pulse_req();
        wait_start_col("f7_col50", 50, 1000);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        cm_cnt = 0;
        exp_q.delete();
        st_col = 0;
        wr_col = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        base_wr = wr_count; base_done = done_count;
        new_pose();
        pulse_req();
        wait_idle("f7_idle", 5000);
        check("f7_writes", wr_count - base_wr, WIDTH);
        check("f7_done", done_count - base_done, 1);
        check("f7_count", frame_count, 1);
        check("f7_first", fb_mem[0], {8'd170, 8'd70, 4'd2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
